// File: rtl/horner_datapath_pkg.sv
// Shared widths, coefficient table type, saturation bounds and arithmetic
// helpers for the Horner evaluation datapath.
package horner_pkg;

  localparam int XW     = 16;       // operand, signed Q1.15
  localparam int AW     = 24;       // accumulator / coefficient, signed Q8.16
  localparam int NCOEFF = 11;       // a0..a10
  localparam int PW     = XW + AW;  // exact product width
  localparam int SW     = AW + 1;   // floor-shifted product width

  // Element i of the table is coefficient a_i.
  typedef logic [0:NCOEFF-1][AW-1:0] coeff_vec_t;

  localparam coeff_vec_t HORNER_COEFF = {NCOEFF{24'h010000}};

  localparam logic signed [AW-1:0] SAT_MAX   = 24'sh7FFFFF;
  localparam logic signed [AW-1:0] SAT_MIN   = 24'sh800000;
  localparam logic signed [AW+1:0] SAT_MAX_W = 26'sh7FFFFF;
  localparam logic signed [AW+1:0] SAT_MIN_W = 26'sh3800000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  function automatic logic signed [AW-1:0] sat_aw(input logic signed [AW+1:0] v);
    logic signed [AW-1:0] r;
    if (v > SAT_MAX_W) begin
      r = SAT_MAX;
    end else if (v < SAT_MIN_W) begin
      r = SAT_MIN;
    end else begin
      r = v[AW-1:0];
    end
    return r;
  endfunction

  // Indices past a10 read as zero.
  function automatic logic signed [AW-1:0] coeff_at(input coeff_vec_t tbl,
                                                    input logic [3:0] k);
    logic signed [AW-1:0] r;
    if (k < 4'(NCOEFF)) begin
      r = tbl[k];
    end else begin
      r = 24'sd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/horner_datapath_if.sv
// Bundle between the control sequencer (master) and the Horner datapath (slave).
interface horner_datapath_if;

  logic [horner_pkg::XW-1:0] x_in;
  logic [3:0]                coeff_sel;
  logic                      sum_rst;
  logic                      sum_en;
  logic                      srdyo;
  logic [horner_pkg::AW-1:0] y_out;
  logic                      y_vld;
  logic                      busy;
  logic                      err;

  modport master (
    output x_in, coeff_sel, sum_rst, sum_en, srdyo,
    input  y_out, y_vld, busy, err
  );

  modport slave (
    input  x_in, coeff_sel, sum_rst, sum_en, srdyo,
    output y_out, y_vld, busy, err
  );

endinterface

// File: rtl/horner_datapath_serial_mult.sv
// 16-cycle signed shift-add multiplier: one multiplier bit per edge, LSB first,
// sign bit subtracted; the exact product is returned floor-shifted by 15.
module serial_mult
  import horner_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic signed [AW-1:0] m_i,
  input  logic        [XW-1:0] x_i,
  output logic                 done_o,
  output logic                 busy_o,
  output logic signed [SW-1:0] prod_o
);

  state_e               state_q;
  logic [3:0]           bit_q;
  logic signed [AW-1:0] m_q;
  logic [XW-1:0]        x_q;
  logic signed [PW-1:0] pp_q;

  logic signed [PW-1:0] first_d;
  logic signed [PW-1:0] shifted_d;
  logic signed [PW-1:0] pp_d;

  // Partial-product step for the current multiplier bit.
  always_comb begin
    first_d   = x_i[0] ? {{XW{m_i[AW-1]}}, m_i} : {PW{1'b0}};
    shifted_d = {{XW{m_q[AW-1]}}, m_q} << bit_q;
    if (!x_q[bit_q]) begin
      pp_d = pp_q;
    end else if (bit_q == 4'd15) begin
      pp_d = pp_q - shifted_d;
    end else begin
      pp_d = pp_q + shifted_d;
    end
  end

  // Slicing off the low 15 bits of a two's-complement value floors it.
  assign prod_o = pp_d[PW-1:XW-1];
  assign busy_o = (state_q == MUL);
  assign done_o = busy_o && (bit_q == 4'd15) && !abort_i && !start_i;

  // Sequencer: a start consumes bit 0 on its own edge, bits 1..15 follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= 4'd0;
      m_q     <= 24'sd0;
      x_q     <= 16'd0;
      pp_q    <= 40'sd0;
    end else if (abort_i) begin
      state_q <= IDLE;
      bit_q   <= 4'd0;
    end else if (start_i) begin
      state_q <= MUL;
      bit_q   <= 4'd1;
      m_q     <= m_i;
      x_q     <= x_i;
      pp_q    <= first_d;
    end else if (state_q == MUL) begin
      pp_q <= pp_d;
      if (bit_q == 4'd15) begin
        state_q <= IDLE;
        bit_q   <= 4'd0;
      end else begin
        bit_q <= bit_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/horner_datapath.sv
// Horner-rule polynomial stage: strobe detection, coefficient select,
// add/saturate into the accumulator, result capture and sticky error flag.
module horner_datapath
  import horner_pkg::*;
#(
  parameter coeff_vec_t COEFF = HORNER_COEFF
) (
  input  logic             clk,
  input  logic             GlobalReset,
  horner_datapath_if.slave bus
);

  logic                 sum_en_q;
  logic [3:0]           coeff_sel_q;
  logic [3:0]           k_q;
  logic [XW-1:0]        x_reg_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] y_q;
  logic                 y_vld_q;
  logic                 err_q;

  logic                 strobe_d;
  logic                 start_d;
  logic                 bad_sel_d;
  logic                 proto_err_d;
  logic [XW-1:0]        mult_x_d;
  logic signed [AW-1:0] coeff_d;
  logic signed [AW+1:0] sum_d;
  logic signed [AW-1:0] acc_d;

  logic                 mult_done;
  logic                 mult_busy;
  logic signed [SW-1:0] mult_prod;

  // Strobe, operand select and the end-of-iteration accumulator value.
  always_comb begin
    strobe_d    = bus.sum_en && (!sum_en_q || (bus.coeff_sel != coeff_sel_q));
    start_d     = strobe_d && !bus.sum_rst;
    bad_sel_d   = (bus.coeff_sel > 4'(NCOEFF - 1));
    mult_x_d    = sum_en_q ? x_reg_q : bus.x_in;
    proto_err_d = (start_d && (mult_busy || bad_sel_d)) || (bus.srdyo && mult_busy);
    coeff_d     = coeff_at(COEFF, k_q);
    sum_d       = {mult_prod[SW-1], mult_prod} + {{2{coeff_d[AW-1]}}, coeff_d};
    acc_d       = sat_aw(sum_d);
  end

  // A restart while busy aborts the running product inside the multiplier.
  serial_mult u_mult (
    .clk     (clk),
    .rst     (GlobalReset),
    .start_i (start_d),
    .abort_i (bus.sum_rst),
    .m_i     (acc_q),
    .x_i     (mult_x_d),
    .done_o  (mult_done),
    .busy_o  (mult_busy),
    .prod_o  (mult_prod)
  );

  // Accumulator, operand hold, result register and error flag.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      sum_en_q    <= 1'b0;
      coeff_sel_q <= 4'd0;
      k_q         <= 4'd0;
      x_reg_q     <= 16'd0;
      acc_q       <= 24'sd0;
      y_q         <= 24'sd0;
      y_vld_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sum_en_q    <= bus.sum_en;
      coeff_sel_q <= bus.coeff_sel;
      y_vld_q     <= bus.srdyo;
      if (bus.srdyo) begin
        y_q <= acc_q;
      end
      if (bus.sum_rst) begin
        acc_q <= 24'sd0;
      end else if (mult_done) begin
        acc_q <= acc_d;
      end
      if (start_d) begin
        k_q <= bus.coeff_sel;
        if (!sum_en_q) begin
          x_reg_q <= bus.x_in;
        end
      end
      if (proto_err_d) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.y_out = y_q;
  assign bus.y_vld = y_vld_q;
  assign bus.busy  = mult_busy;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_horner_datapath.sv
// Directed bench: three datapaths with different coefficient tables share one
// control stream and are checked every cycle against an arithmetic reference.
module tb_horner_datapath;
  import horner_pkg::*;

  localparam coeff_vec_t COEFF_NOM = {NCOEFF{24'h010000}};
  localparam coeff_vec_t COEFF_ALT = {{5{24'h010000, 24'hFF0000}}, 24'h010000};
  localparam coeff_vec_t COEFF_SAT = {NCOEFF{24'h7FFFFF}};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x_in_s;
  logic [3:0]  csel_s;
  logic        sum_rst_s;
  logic        sum_en_s;
  logic        srdyo_s;

  logic [23:0] y_out_w [3];
  logic        y_vld_w [3];
  logic        busy_w  [3];
  logic        err_w   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    horner_datapath_if bus ();
    assign bus.x_in      = x_in_s;
    assign bus.coeff_sel = csel_s;
    assign bus.sum_rst   = sum_rst_s;
    assign bus.sum_en    = sum_en_s;
    assign bus.srdyo     = srdyo_s;
    assign y_out_w[g]    = bus.y_out;
    assign y_vld_w[g]    = bus.y_vld;
    assign busy_w[g]     = bus.busy;
    assign err_w[g]      = bus.err;

    horner_datapath #(
      .COEFF(g == 0 ? COEFF_NOM : (g == 1 ? COEFF_ALT : COEFF_SAT))
    ) dut (
      .clk         (clk),
      .GlobalReset (rst),
      .bus         (bus)
    );
  end

  task automatic check(input string name, input int inst,
                       input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d at %0t: got %h, want %h", name, inst, $time, got, want);
    end
  endtask

  // Reference coefficients: 0 = all 1.0, 1 = +1/-1 alternating, 2 = max positive.
  function automatic longint ref_coef(input int inst, input int k);
    if (k > 10) return 0;
    if (inst == 0) return 65536;
    if (inst == 1) return (k % 2 == 0) ? 65536 : -65536;
    return 8388607;
  endfunction

  function automatic longint ref_step(input int inst, input longint mm,
                                      input longint xx, input int k);
    longint q;
    q = ((mm * xx) >>> 15) + ref_coef(inst, k);
    if (q > 8388607) q = 8388607;
    if (q < -8388608) q = -8388608;
    return q;
  endfunction

  // Reference model state
  longint m_acc [3];
  longint m_mul [3];
  longint m_yout[3];
  longint m_x, m_xreg;
  bit     m_yvld, m_err, m_act, m_sen_q, busy_exp, strobe, busy_now, done;
  int     m_csel_q, m_k, m_scyc, cyc;

  initial begin
    cyc = 0; m_act = 0; m_err = 0; m_yvld = 0; m_sen_q = 0;
    m_csel_q = 0; m_k = 0; m_scyc = 0; m_x = 0; m_xreg = 0;
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_mul[i] = 0; m_yout[i] = 0;
    end
    forever begin
      @(negedge clk);
      busy_exp = m_act && (cyc > m_scyc);
      for (int i = 0; i < 3; i++) begin
        check("y_out", i, y_out_w[i], 24'(m_yout[i]));
        check("y_vld", i, 24'(y_vld_w[i]), 24'(m_yvld));
        check("busy", i, 24'(busy_w[i]), 24'(busy_exp));
        check("err", i, 24'(err_w[i]), 24'(m_err));
      end
      if (rst) begin
        m_act = 0; m_err = 0; m_yvld = 0; m_sen_q = 0; m_csel_q = 0; m_xreg = 0;
        for (int i = 0; i < 3; i++) begin
          m_acc[i] = 0; m_yout[i] = 0;
        end
      end else begin
        strobe   = sum_en_s && (!m_sen_q || (int'(csel_s) != m_csel_q));
        busy_now = m_act && (cyc > m_scyc);
        done     = m_act && (cyc == m_scyc + 15);
        m_yvld   = srdyo_s;
        if (srdyo_s) begin
          for (int i = 0; i < 3; i++) m_yout[i] = m_acc[i];
          if (busy_now) m_err = 1;
        end
        if (sum_rst_s) begin
          for (int i = 0; i < 3; i++) m_acc[i] = 0;
          m_act = 0;
        end else if (strobe) begin
          if (busy_now || csel_s > 4'd10) m_err = 1;
          if (!m_sen_q) m_xreg = longint'($signed(x_in_s));
          m_x = m_xreg;
          for (int i = 0; i < 3; i++) m_mul[i] = m_acc[i];
          m_k = int'(csel_s);
          m_scyc = cyc;
          m_act = 1;
        end else if (done) begin
          for (int i = 0; i < 3; i++) m_acc[i] = ref_step(i, m_mul[i], m_x, m_k);
          m_act = 0;
        end
        m_sen_q  = sum_en_s;
        m_csel_q = int'(csel_s);
      end
      cyc++;
    end
  end

  // One evaluation on the control timeline; variant 1 aborts at cnt 40,
  // 2 glitches coeff_sel while busy, 3 applies GlobalReset at cnt 100.
  task automatic run_eval(input logic [15:0] x, input int variant,
                          input int lit_inst, input logic [23:0] lit_val,
                          input logic lit_err);
    for (int cnt = 0; cnt < 206; cnt++) begin
      @(posedge clk);
      #1;
      sum_rst_s = (cnt == 1) || (variant == 1 && cnt == 40);
      sum_en_s  = (cnt >= 18 && cnt <= 193);
      csel_s    = (cnt >= 18 && cnt <= 193) ? 4'(10 - (cnt - 18) / 16) : 4'd0;
      if (variant == 2 && cnt >= 60 && cnt < 66) csel_s = 4'd12;
      srdyo_s   = (cnt == 197) || (variant == 1 && cnt == 41) || (variant == 2 && cnt == 70);
      x_in_s    = (cnt == 18) ? x : 16'hA5A5;
      rst       = (variant == 3 && cnt == 100);
      if (variant == 3 && cnt > 100) begin
        sum_rst_s = 1'b0; sum_en_s = 1'b0; csel_s = 4'd0; srdyo_s = 1'b0;
      end
      #1;
      if (variant == 1 && cnt == 41) check("abort_busy", 0, 24'(busy_w[0]), 24'd0);
      if (variant == 1 && cnt == 42) begin
        check("abort_acc", 0, y_out_w[0], 24'd0);
        check("abort_vld", 0, 24'(y_vld_w[0]), 24'd1);
      end
      if (variant == 3 && cnt == 101) begin
        check("rst_y_out", 0, y_out_w[0], 24'd0);
        check("rst_y_vld", 0, 24'(y_vld_w[0]), 24'd0);
        check("rst_busy", 0, 24'(busy_w[0]), 24'd0);
        check("rst_err", 0, 24'(err_w[0]), 24'd0);
      end
      if (cnt == 198) begin
        check("lit_y_out", lit_inst, y_out_w[lit_inst], lit_val);
        check("lit_y_vld", lit_inst, 24'(y_vld_w[lit_inst]), 24'(variant != 3));
        check("lit_err", lit_inst, 24'(err_w[lit_inst]), 24'(lit_err));
      end
    end
  endtask

  initial begin
    rst = 1'b1; x_in_s = 16'd0; csel_s = 4'd0;
    sum_rst_s = 1'b0; sum_en_s = 1'b0; srdyo_s = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("reset_y_out", 0, y_out_w[0], 24'd0);
    check("reset_err", 0, 24'(err_w[0]), 24'd0);

    run_eval(16'h4000, 0, 0, 24'h01FFC0, 1'b0);  // 0.5, geometric series
    run_eval(16'h8000, 0, 1, 24'h0B0000, 1'b0);  // -1.0, alternating coeffs
    run_eval(16'h7FFF, 0, 2, 24'h7FFFFF, 1'b0);  // saturation
    run_eval(16'hFFFD, 0, 0, 24'h00FFFA, 1'b0);  // floor of negative products
    run_eval(16'h4000, 1, 0, 24'h01FF00, 1'b0);  // abort at cnt 40
    run_eval(16'h4000, 2, 0, 24'h01FF80, 1'b1);  // restarts while busy, bad index
    run_eval(16'h4000, 0, 0, 24'h01FFC0, 1'b1);  // clean run, err stays set
    run_eval(16'h4000, 3, 0, 24'h000000, 1'b0);  // GlobalReset at cnt 100
    run_eval(16'h4000, 0, 0, 24'h01FFC0, 1'b0);  // nominal after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/horner_datapath.md
# horner_datapath

Arithmetic stage directly downstream of `control` in the polynomial evaluator. It consumes `coeff_sel`, `sum_rst`, `sum_en` and `srdyo` from `control`, together with the centred/scaled operand `x_in` from the center/scale stage. It evaluates y = a10·x^10 + … + a0 by Horner's rule: one 16-cycle serial shift-add iteration per coefficient. The final result is registered for the output interface.

## Interface
- `XW`, 16: operand width, signed Q1.15.
- `AW`, 24: accumulator/coefficient width, signed Q8.16.
- `NCOEFF`, 11: number of coefficients, a0..a10.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `GlobalReset`  in  1  synchronous, active-high reset.
- `x_in`  in  XW  scaled operand; valid on the cycle `sum_en` first rises.
- `coeff_sel`  in  4  coefficient index from `control`; holds its value between changes.
- `sum_rst`  in  1  one-cycle pulse; clears the accumulator.
- `sum_en`  in  1  level; enables Horner iterations.
- `srdyo`  in  1  one-cycle pulse from `control`; the final result is due.
- `y_out`  out  AW  registered result, Q8.16.
- `y_vld`  out  1  one-cycle pulse; `y_out` is new.
- `busy`  out  1  a serial iteration is in progress.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Strobe definition: `strobe` = `sum_en` & (`sum_en_q`==0 | `coeff_sel` != `coeff_sel_q`).
  - `sum_en_q` and `coeff_sel_q` are 1-cycle registered copies of the inputs.
- On a strobe in cycle S:
  - Latch `k` = `coeff_sel`.
  - Latch multiplicand M = `acc`.
  - If this is the first strobe (`sum_en_q`==0), also load `x_reg` <= `x_in`. The multiplier is `x_in` on that strobe and `x_reg` on every later strobe.
- Serial multiply: one multiplier bit per edge, LSB first.
  - Bit 0 at the edge ending S; bits 1..15 at the edges ending S+1..S+15.
  - Bit 15 is weighted −2^15 (two's complement), so it is a subtract.
  - The partial product is exact, 40 bits, with no intermediate rounding.
- At the edge ending S+15: `acc` <= sat_AW( floor(M·x / 2^15) + a[k] ).
  - floor is an arithmetic shift: round toward −∞.
  - sat clamps to [−2^23, 2^23−1].
  - `coeff_sel` > 10 selects a[k] = 0 and sets `err`.
- State machine: IDLE → MUL (bit counter 0..15) → IDLE. `busy` is high in MUL, i.e. cycles S+1..S+15.
- `sum_rst`:
  - `acc` <= 0.
  - Any iteration in progress is aborted: return to IDLE, no `acc` write.
  - `sum_rst` has priority over a strobe in the same cycle.
- Strobe while `busy`: set `err`, abort the current iteration, start a new one using the current `acc`.
- `srdyo`:
  - `y_out` <= `acc` at that edge, and `y_vld` = 1 for exactly the next cycle.
  - If `busy` is high in the same cycle, capture anyway and set `err`.
- `err` clears only on `GlobalReset`.
- `GlobalReset`: all of the following <= 0, and the state machine goes to IDLE.
  - `acc`, `x_reg`, `y_out`, `y_vld`, `busy`, `err`, bit counter, `sum_en_q`, `coeff_sel_q`.
  - Reset mid-iteration discards that iteration.

## Timing
- Cycles are counted as `control`'s cnt; `srdyi` is at cnt 0.
  - `sum_rst` at cnt 1.
  - Strobes at cnt 18, 34, …, 178; the first uses a10, the last uses a0.
  - `srdyo` at cnt 197.
- Each iteration updates `acc` at the edge ending S+15, so `acc` is valid from S+16. This meets the next strobe at S+16 with zero slack.
  - The last update lands at the edge ending cnt 193.
- `y_out`/`y_vld` are valid at cnt 198: 1-cycle latency from `srdyo`.
- Back-to-back evaluations: a new `sum_rst` may arrive any time after cnt 197. `y_out` holds its value until the next `srdyo`.
- `busy` deasserts in the cycle of each strobe-period boundary before the next strobe reasserts it. It is never continuously high across two iterations in legal operation.

## Structure
- Package `horner_pkg` holds:
  - `XW`, `AW`, `NCOEFF`.
  - The coefficient constant array `HORNER_COEFF[0:10]` (Q8.16).
  - The saturation bounds.
  - The state enum {IDLE, MUL}.
- One sub-module, `serial_mult`: 16-cycle signed shift-add multiplier.
  - Inputs: start, abort, M, x.
  - Outputs: done pulse, floor-shifted product.
- Top level keeps the strobe detection, coefficient mux, add/saturate, result register and `err`.

## Test plan
- Nominal run, x_in = 0x4000 (0.5), all coefficients 1.0 (0x010000) → `y_out` = sum of 0.5^i for i = 0..10 (geometric series), floored at each step; `y_vld` high at cnt 198 only.
- x_in = 0x8000 (−1.0), alternating ±1.0 coefficients → exact expected value; checks the bit-15 subtract and floor of negatives.
- Large coefficients (0x7FFFFF) with x_in = 0x7FFF → `acc` saturates at 0x7FFFFF, never wraps.
- `sum_rst` injected at cnt 40, mid-iteration → `acc` = 0, `busy` low next cycle, no write at cnt 49.
- Extra `coeff_sel` change while `busy`, and `coeff_sel` = 12 → `err` = 1 and sticky; a following clean run still produces the correct `y_out`.
- `GlobalReset` at cnt 100 → all outputs 0 next cycle; a subsequent full run produces the nominal result.
